hbm_rd_return_arbiter: RTL and testbench

- Sits in the dfi_clk domain between the HBM DFI read-return bus and the dfi→fabric CDC FIFO.
- Splits each DFI read beat into per-pseudo-channel (PC0/PC1) 256-bit words and buffers each in a small per-PC queue.
- Round-robin arbitrates the two queues into a single write stream toward the CDC FIFO, honouring its backpressure.
- Correctly serialises simultaneous PC0+PC1 returns (valid=4'b1111), which must not be dropped.

---
 rtl/hbm_rd_pkg.sv | 32 +++
 rtl/hbm_rd_pc_queue.sv | 61 ++++++
 rtl/hbm_rd_return_arbiter.sv | 135 +++++++++++++
 tb/tb_hbm_rd_return_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbm_rd_pkg.sv
// ----------------------------------------------------------------------------
// hbm_rd_pkg
// Constants and helpers shared by the HBM readback path. The functions split
// one DFI read beat (two 256-bit phases) into the 256-bit word of each
// pseudo-channel.
// ----------------------------------------------------------------------------
package hbm_rd_pkg;

    localparam int PC_W    = 256;  // one pseudo-channel word
    localparam int DFI_W   = 256;  // one DFI read-data phase
    localparam int VALID_W = 4;    // [1:0] PC0 pair, [3:2] PC1 pair
    localparam int PC0     = 0;
    localparam int PC1     = 1;

    typedef enum logic {
        PC_ID0 = 1'b0,
        PC_ID1 = 1'b1
    } pc_id_e;

    // PC0 owns the low 64 bits of each 128-bit half of both phases.
    function automatic logic [PC_W-1:0] extract_pc0(input logic [DFI_W-1:0] p0,
                                                    input logic [DFI_W-1:0] p1);
        return {p1[191:128], p1[63:0], p0[191:128], p0[63:0]};
    endfunction

    // PC1 owns the high 64 bits of each 128-bit half of both phases.
    function automatic logic [PC_W-1:0] extract_pc1(input logic [DFI_W-1:0] p0,
                                                    input logic [DFI_W-1:0] p1);
        return {p1[255:192], p1[127:64], p0[255:192], p0[127:64]};
    endfunction

endpackage

// File: rtl/hbm_rd_pc_queue.sv
// ----------------------------------------------------------------------------
// hbm_rd_pc_queue
// Single-clock show-ahead FIFO holding returned words of one pseudo-channel.
// A push to a full queue is accepted only when a pop happens in the same
// cycle; a pop of an empty queue is ignored.
//   clk, rst  : clock, synchronous active-high reset (empties the queue)
//   push      : write wr_data this cycle
//   pop       : retire the head entry this cycle
//   wr_data   : incoming word
//   rd_data   : head entry (valid while !empty)
//   full      : DEPTH entries held
//   empty     : no entries held
// ----------------------------------------------------------------------------
module hbm_rd_pc_queue #(
    parameter int DEPTH = 8,
    parameter int W     = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB tells a wrapped (full) queue from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous, hence only clk in the list.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; pointers alone define which
    // entries are valid, and leaving the array unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/hbm_rd_return_arbiter.sv
// ----------------------------------------------------------------------------
// hbm_rd_return_arbiter
// Splits each DFI read beat into PC0/PC1 words, queues them per PC and
// round-robins the queues into one write stream toward the CDC FIFO.
//   dfi_clk, dfi_rst         : clock, synchronous active-high reset
//   dfi_0_dw_rddata_p0/p1    : DFI read data phases
//   dfi_0_dw_rddata_valid    : [1:0] PC0 valid pair, [3:2] PC1 valid pair
//   i_fifo_full              : CDC FIFO full, blocks the grant decision
//   i_clr_err                : clears sticky error flags (new events win)
//   o_wr_en/o_wr_data/o_pc_id: registered write toward the CDC FIFO
//   o_ovf, o_bad_valid       : sticky queue-overflow / broken valid pair
//   o_ret_cnt0/1             : words accepted into each PC queue
// ----------------------------------------------------------------------------
module hbm_rd_return_arbiter
    import hbm_rd_pkg::*;
#(
    parameter int QDEPTH = 8,
    parameter int CNT_W  = 32
) (
    input  logic                dfi_clk,
    input  logic                dfi_rst,
    input  logic [DFI_W-1:0]    dfi_0_dw_rddata_p0,
    input  logic [DFI_W-1:0]    dfi_0_dw_rddata_p1,
    input  logic [VALID_W-1:0]  dfi_0_dw_rddata_valid,
    input  logic                i_fifo_full,
    input  logic                i_clr_err,
    output logic                o_wr_en,
    output logic [2*PC_W-1:0]   o_wr_data,
    output logic                o_pc_id,
    output logic [1:0]          o_ovf,
    output logic                o_bad_valid,
    output logic [CNT_W-1:0]    o_ret_cnt0,
    output logic [CNT_W-1:0]    o_ret_cnt1
);

    logic [PC_W-1:0] word    [2];
    logic [PC_W-1:0] rd_data [2];
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [1:0]      full;
    logic [1:0]      empty;
    logic [1:0]      accept;
    logic [1:0]      ovf_evt;
    logic            bad_evt;

    logic            grant_vld;
    logic            grant_tie;
    pc_id_e          grant_pc;
    pc_id_e          last_grant;

    assign word[PC0] = extract_pc0(dfi_0_dw_rddata_p0, dfi_0_dw_rddata_p1);
    assign word[PC1] = extract_pc1(dfi_0_dw_rddata_p0, dfi_0_dw_rddata_p1);

    // A pair must be 11 to carry a word; 01/10 is a protocol error.
    assign push[PC0] = (dfi_0_dw_rddata_valid[1:0] == 2'b11);
    assign push[PC1] = (dfi_0_dw_rddata_valid[3:2] == 2'b11);
    assign bad_evt   = (^dfi_0_dw_rddata_valid[1:0]) | (^dfi_0_dw_rddata_valid[3:2]);

    // Mirrors the queue's own acceptance rule: a same-cycle pop frees a slot.
    assign accept  = push & (~full | pop);
    assign ovf_evt = push & full & ~pop;

    for (genvar g = 0; g < 2; g++) begin : g_queue
        hbm_rd_pc_queue #(
            .DEPTH (QDEPTH),
            .W     (PC_W)
        ) u_queue (
            .clk     (dfi_clk),
            .rst     (dfi_rst),
            .push    (push[g]),
            .pop     (pop[g]),
            .wr_data (word[g]),
            .rd_data (rd_data[g]),
            .full    (full[g]),
            .empty   (empty[g])
        );
    end

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_vld = 1'b0;
        grant_tie = 1'b0;
        grant_pc  = PC_ID0;
        if (!i_fifo_full) begin
            if (!empty[PC0] && !empty[PC1]) begin
                grant_vld = 1'b1;
                grant_tie = 1'b1;
                grant_pc  = (last_grant == PC_ID0) ? PC_ID1 : PC_ID0;
            end else if (!empty[PC0]) begin
                grant_vld = 1'b1;
                grant_pc  = PC_ID0;
            end else if (!empty[PC1]) begin
                grant_vld = 1'b1;
                grant_pc  = PC_ID1;
            end
        end
    end

    assign pop[PC0] = grant_vld && (grant_pc == PC_ID0);
    assign pop[PC1] = grant_vld && (grant_pc == PC_ID1);

    always_ff @(posedge dfi_clk) begin
        if (dfi_rst) begin
            o_wr_en     <= 1'b0;
            o_wr_data   <= '0;
            o_pc_id     <= 1'b0;
            o_ovf       <= 2'b00;
            o_bad_valid <= 1'b0;
            o_ret_cnt0  <= '0;
            o_ret_cnt1  <= '0;
            last_grant  <= PC_ID1;      // PC0 wins the first tie
        end else begin
            o_wr_en <= grant_vld;
            o_pc_id <= grant_pc;
            if (!grant_vld)
                o_wr_data <= '0;
            else if (grant_pc == PC_ID1)
                o_wr_data <= {rd_data[PC1], {PC_W{1'b0}}};
            else
                o_wr_data <= {{PC_W{1'b0}}, rd_data[PC0]};

            // Round-robin state only advances on contested grants.
            if (grant_tie) last_grant <= grant_pc;

            // Clear first, then OR in new events so a same-cycle event wins.
            o_ovf       <= (o_ovf & {2{~i_clr_err}}) | ovf_evt;
            o_bad_valid <= (o_bad_valid & ~i_clr_err) | bad_evt;

            if (accept[PC0]) o_ret_cnt0 <= o_ret_cnt0 + 1'b1;
            if (accept[PC1]) o_ret_cnt1 <= o_ret_cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_hbm_rd_return_arbiter.sv
// ----------------------------------------------------------------------------
// tb_hbm_rd_return_arbiter
// Directed bench for hbm_rd_return_arbiter. Inputs are driven 1 ns after the
// rising edge, outputs are read at that point, and a monitor on the falling
// edge logs every write into a queue for ordering checks.
// ----------------------------------------------------------------------------
module tb_hbm_rd_return_arbiter;

    localparam int QDEPTH = 8;
    localparam int CNT_W  = 32;

    logic          dfi_clk = 1'b0;
    logic          dfi_rst;
    logic [255:0]  p0;
    logic [255:0]  p1;
    logic [3:0]    valid;
    logic          fifo_full;
    logic          clr_err;
    logic          wr_en;
    logic [511:0]  wr_data;
    logic          pc_id;
    logic [1:0]    ovf;
    logic          bad_valid;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic         pc;
        logic [511:0] data;
    } wr_t;
    wr_t wq[$];

    always #5 dfi_clk = ~dfi_clk;

    hbm_rd_return_arbiter #(
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .dfi_clk               (dfi_clk),
        .dfi_rst               (dfi_rst),
        .dfi_0_dw_rddata_p0    (p0),
        .dfi_0_dw_rddata_p1    (p1),
        .dfi_0_dw_rddata_valid (valid),
        .i_fifo_full           (fifo_full),
        .i_clr_err             (clr_err),
        .o_wr_en               (wr_en),
        .o_wr_data             (wr_data),
        .o_pc_id               (pc_id),
        .o_ovf                 (ovf),
        .o_bad_valid           (bad_valid),
        .o_ret_cnt0            (cnt0),
        .o_ret_cnt1            (cnt1)
    );

    always @(negedge dfi_clk) begin
        if (wr_en) wq.push_back('{pc_id, wr_data});
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge dfi_clk);
        #1;
    endtask

    // 64-bit lane i (0..3 = phase 0, 4..7 = phase 1) of beat s.
    function automatic logic [63:0] lane(input int s, input int i);
        logic [15:0] sv;
        logic [15:0] iv;
        sv = s[15:0];
        iv = i[15:0];
        return {16'hC0DE, 16'h0000, sv, iv};
    endfunction

    // Hand derivation: PC0 = {p1 lane2, p1 lane0, p0 lane2, p0 lane0},
    // PC1 = {p1 lane3, p1 lane1, p0 lane3, p0 lane1}.
    function automatic logic [511:0] exp_wr(input int s, input logic pc);
        if (pc)
            return {lane(s, 7), lane(s, 5), lane(s, 3), lane(s, 1), 256'b0};
        else
            return {256'b0, lane(s, 6), lane(s, 4), lane(s, 2), lane(s, 0)};
    endfunction

    task automatic beat(input logic [3:0] v, input int s);
        valid = v;
        p0    = {lane(s, 3), lane(s, 2), lane(s, 1), lane(s, 0)};
        p1    = {lane(s, 7), lane(s, 6), lane(s, 5), lane(s, 4)};
    endtask

    task automatic idle();
        valid = 4'b0000;
        p0    = '0;
        p1    = '0;
    endtask

    task automatic do_reset();
        idle();
        fifo_full = 1'b0;
        clr_err   = 1'b0;
        dfi_rst   = 1'b1;
        tick();
        dfi_rst   = 1'b0;
        wq.delete();
    endtask

    task automatic check_wr(input string tag, input logic pc, input int s);
        wr_t w;
        if (wq.size() == 0) begin
            check({tag, " present"}, 0, 1);
            return;
        end
        w = wq.pop_front();
        check({tag, " pc"}, w.pc, pc);
        check({tag, " data"}, w.data, exp_wr(s, pc));
    endtask

    // Single PC0 beat: pushed at edge 1, granted in the next cycle, visible
    // on o_wr_en after edge 2.
    task automatic single_pc0(input string tag);
        beat(4'b0011, 1);
        tick();
        idle();
        check({tag, " wr_en early"}, wr_en, 0);
        check({tag, " cnt0"}, cnt0, 1);
        tick();
        check({tag, " wr_en"}, wr_en, 1);
        check({tag, " pc_id"}, pc_id, 0);
        check({tag, " data"}, wr_data, exp_wr(1, 1'b0));
        check({tag, " cnt1"}, cnt1, 0);
        tick();
        check({tag, " wr_en drop"}, wr_en, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        fifo_full = 1'b0;
        clr_err   = 1'b0;
        dfi_rst   = 1'b1;
        tick(2);
        dfi_rst = 1'b0;
        wq.delete();

        // Reset state
        check("rst wr_en", wr_en, 0);
        check("rst wr_data", wr_data, 0);
        check("rst pc_id", pc_id, 0);
        check("rst ovf", ovf, 0);
        check("rst bad_valid", bad_valid, 0);
        check("rst cnt0", cnt0, 0);
        check("rst cnt1", cnt1, 0);

        // Single PC0 return
        single_pc0("t1");

        // Simultaneous PC0+PC1: PC0 first (initial tie), then PC1
        do_reset();
        beat(4'b1111, 2);
        tick();
        idle();
        tick(4);
        check("t2 writes", wq.size(), 2);
        check_wr("t2 w0", 1'b0, 2);
        check_wr("t2 w1", 1'b1, 2);
        check("t2 cnt0", cnt0, 1);
        check("t2 cnt1", cnt1, 1);

        // Sustained 1111 for 4 cycles: 8 alternating writes
        do_reset();
        for (int k = 0; k < 4; k++) begin
            beat(4'b1111, 10 + k);
            tick();
        end
        idle();
        tick(12);
        check("t3 writes", wq.size(), 8);
        for (int j = 0; j < 8; j++)
            check_wr($sformatf("t3 w%0d", j), j[0], 10 + j / 2);
        check("t3 ovf", ovf, 0);
        check("t3 cnt0", cnt0, 4);
        check("t3 cnt1", cnt1, 4);

        // Backpressure: 9 PC0 beats while full, 9th overflows
        do_reset();
        fifo_full = 1'b1;
        for (int k = 0; k < 9; k++) begin
            beat(4'b0011, 20 + k);
            tick();
        end
        idle();
        tick(2);
        check("t4 no writes", wq.size(), 0);
        check("t4 ovf", ovf, 2'b01);
        check("t4 cnt0", cnt0, 8);
        fifo_full = 1'b0;
        tick(12);
        check("t4 writes", wq.size(), 8);
        for (int j = 0; j < 8; j++)
            check_wr($sformatf("t4 w%0d", j), 1'b0, 20 + j);
        check("t4 cnt0 hold", cnt0, 8);
        check("t4 ovf sticky", ovf, 2'b01);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t4 ovf clr", ovf, 2'b00);

        // Protocol error, set-wins-over-clear, then clear
        do_reset();
        beat(4'b0001, 30);
        tick();
        idle();
        tick(3);
        check("t5 bad_valid", bad_valid, 1);
        check("t5 cnt0", cnt0, 0);
        check("t5 no writes", wq.size(), 0);
        beat(4'b1000, 31);
        clr_err = 1'b1;
        tick();
        idle();
        clr_err = 1'b0;
        check("t5 set wins", bad_valid, 1);
        check("t5 cnt1", cnt1, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t5 bad clr", bad_valid, 0);

        // Reset mid-stream with 5 words queued and a sticky error set
        do_reset();
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            beat(4'b0011, 40 + k);
            tick();
        end
        beat(4'b0010, 45);
        tick();
        idle();
        check("t6 pre cnt0", cnt0, 5);
        check("t6 pre bad", bad_valid, 1);
        fifo_full = 1'b0;
        dfi_rst   = 1'b1;
        tick();
        dfi_rst   = 1'b0;
        check("t6 wr_en rst", wr_en, 0);
        tick();
        check("t6 wr_en after", wr_en, 0);
        check("t6 cnt0", cnt0, 0);
        check("t6 bad", bad_valid, 0);
        check("t6 ovf", ovf, 0);
        tick(3);
        check("t6 no writes", wq.size(), 0);
        wq.delete();
        single_pc0("t6 again");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
